// File: rtl/mbus_tx_arbiter_pkg.sv
// Shared MBus definitions for the layer-controller transmit path:
// bus widths and the transmit arbiter state encoding.
package mbus_tx_arbiter_pkg;

    localparam int MBUS_ADDR_WIDTH = 32;
    localparam int MBUS_DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GRANT   = 3'd1,
        ST_SEND    = 3'd2,
        ST_ACKLOW  = 3'd3,
        ST_NEXTW   = 3'd4,
        ST_WRESP   = 3'd5,
        ST_RESPACK = 3'd6
    } tx_state_e;

endpackage

// File: rtl/mbus_tx_arbiter_sync2.sv
// Two-flop synchroniser bringing bus-clock handshake levels into the layer clock.
module mbus_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;

    // Metastability stage followed by the output stage
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta_r <= '0;
            q      <= '0;
        end else begin
            meta_r <= d;
            q      <= meta_r;
        end
    end

endmodule

// File: rtl/mbus_tx_arbiter.sv
// Shares one MBus node transmit interface among NUM_REQ requesters: whole-message
// arbitration (priority, then round-robin) and the four-phase word/response handshake.
module mbus_tx_arbiter
    import mbus_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = MBUS_ADDR_WIDTH,
    parameter int DATA_WIDTH = MBUS_DATA_WIDTH
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_pend,
    input  logic [NUM_REQ-1:0]            req_priority,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic                          resp_succ,
    output logic [ADDR_WIDTH-1:0]         tx_addr,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic                          tx_req,
    output logic                          tx_pend,
    output logic                          tx_priority,
    output logic                          tx_resp_ack,
    input  logic                          tx_ack,
    input  logic                          tx_succ,
    input  logic                          tx_fail
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [2:0]            sync_in_s;
    logic [2:0]            sync_out_s;
    logic                  ack_s;
    logic                  succ_s;
    logic                  fail_s;
    logic                  result_s;
    logic                  succ_res_s;
    tx_state_e             state_r;
    logic [IDX_W-1:0]      grant_r;
    logic [IDX_W-1:0]      rr_ptr_r;
    logic [IDX_W-1:0]      pick_s;
    logic [NUM_REQ-1:0]    prio_mask_s;
    logic [NUM_REQ-1:0]    cand_s;
    logic                  any_prio_s;
    logic [NUM_REQ-1:0]    grant_hot_s;
    logic [ADDR_WIDTH-1:0] addr_arr_s [NUM_REQ];
    logic [DATA_WIDTH-1:0] data_arr_s [NUM_REQ];

    // First set bit of mask, searching upward from ptr with wrap-around
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] mask,
                                                 input logic [IDX_W-1:0]   ptr);
        logic [IDX_W:0]   pos;
        logic [IDX_W-1:0] sel;
        logic             found;
        sel   = ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = {1'b0, ptr} + (IDX_W+1)'(k);
            pos = (pos >= (IDX_W+1)'(NUM_REQ)) ? pos - (IDX_W+1)'(NUM_REQ) : pos;
            if (!found && mask[pos[IDX_W-1:0]]) begin
                sel   = pos[IDX_W-1:0];
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] g);
        return (g == IDX_W'(NUM_REQ - 1)) ? '0 : g + IDX_W'(1);
    endfunction

    assign sync_in_s = {tx_ack, tx_succ, tx_fail};

    mbus_sync2 #(.WIDTH(3)) u_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (sync_in_s),
        .q      (sync_out_s)
    );

    assign ack_s       = sync_out_s[2];
    assign succ_s      = sync_out_s[1];
    assign fail_s      = sync_out_s[0];
    assign result_s    = succ_s | fail_s;
    assign succ_res_s  = succ_s & ~fail_s;
    assign grant_hot_s = NUM_REQ'(1) << grant_r;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_arr_s[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign data_arr_s[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Winner selection: priority requesters mask out the rest, then round-robin
    always_comb begin
        prio_mask_s = req_valid & req_priority;
        any_prio_s  = |prio_mask_s;
        cand_s      = req_valid;
        if (any_prio_s) begin
            cand_s = prio_mask_s;
        end else begin
            cand_s = req_valid;
        end
        pick_s = rr_pick(cand_s, rr_ptr_r);
    end

    // Message sequencer; a result seen before the last word completes aborts the message
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= ST_IDLE;
            grant_r     <= '0;
            rr_ptr_r    <= '0;
            req_ready   <= '0;
            resp_valid  <= '0;
            resp_succ   <= 1'b0;
            tx_addr     <= '0;
            tx_data     <= '0;
            tx_req      <= 1'b0;
            tx_pend     <= 1'b0;
            tx_priority <= 1'b0;
            tx_resp_ack <= 1'b0;
        end else begin
            req_ready  <= '0;
            resp_valid <= '0;
            case (state_r)
                ST_IDLE: begin
                    if (|req_valid) begin
                        grant_r     <= pick_s;
                        tx_addr     <= addr_arr_s[pick_s];
                        tx_priority <= any_prio_s;
                        state_r     <= ST_GRANT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    tx_data <= data_arr_s[grant_r];
                    tx_pend <= req_pend[grant_r];
                    tx_req  <= 1'b1;
                    state_r <= ST_SEND;
                end
                ST_SEND: begin
                    if (result_s) begin
                        tx_req      <= 1'b0;
                        tx_pend     <= 1'b0;
                        tx_resp_ack <= 1'b1;
                        resp_succ   <= succ_res_s;
                        state_r     <= ST_RESPACK;
                    end else if (ack_s) begin
                        tx_req    <= 1'b0;
                        req_ready <= grant_hot_s;
                        state_r   <= ST_ACKLOW;
                    end else begin
                        state_r <= ST_SEND;
                    end
                end
                ST_ACKLOW: begin
                    if (result_s) begin
                        tx_pend     <= 1'b0;
                        tx_resp_ack <= 1'b1;
                        resp_succ   <= succ_res_s;
                        state_r     <= ST_RESPACK;
                    end else if (!ack_s) begin
                        state_r <= tx_pend ? ST_NEXTW : ST_WRESP;
                    end else begin
                        state_r <= ST_ACKLOW;
                    end
                end
                ST_NEXTW: begin
                    if (result_s) begin
                        tx_pend     <= 1'b0;
                        tx_resp_ack <= 1'b1;
                        resp_succ   <= succ_res_s;
                        state_r     <= ST_RESPACK;
                    end else if (req_valid[grant_r]) begin
                        state_r <= ST_GRANT;
                    end else begin
                        state_r <= ST_NEXTW;
                    end
                end
                ST_WRESP: begin
                    if (result_s) begin
                        tx_resp_ack <= 1'b1;
                        resp_succ   <= succ_res_s;
                        state_r     <= ST_RESPACK;
                    end else begin
                        state_r <= ST_WRESP;
                    end
                end
                ST_RESPACK: begin
                    if (!succ_s && !fail_s) begin
                        tx_resp_ack <= 1'b0;
                        resp_valid  <= grant_hot_s;
                        rr_ptr_r    <= next_idx(grant_r);
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r <= ST_RESPACK;
                    end
                end
                default: begin
                    tx_req      <= 1'b0;
                    tx_pend     <= 1'b0;
                    tx_resp_ack <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mbus_tx_arbiter.sv
// Randomised scoreboard bench for mbus_tx_arbiter: requester and node models,
// expected service order from a message-level arbitration model.
module tb_mbus_tx_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int K_SUCC = 0, K_FAIL = 1, K_BOTH = 2, K_EARLY = 3;

    typedef struct {
        int              idx;
        logic [31:0]     addr;
        bit              prio;
        bit              prio_out;
        int              nw;
        logic [3:0][31:0] data;
        logic [3:0][7:0]  gap;
        int              kind;
    } msg_t;

    logic              clk, resetn;
    logic [N-1:0]      req_valid, req_pend, req_priority, req_ready, resp_valid;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_data;
    logic              resp_succ, tx_req, tx_pend, tx_priority, tx_resp_ack;
    logic [AW-1:0]     tx_addr;
    logic [DW-1:0]     tx_data;
    logic              tx_ack, tx_succ, tx_fail;

    int   checks, failures;
    int   batch_id;
    int   m_ptr;
    bit   hold;
    msg_t new_msg [N];
    bit   new_has [N];
    msg_t exp_q [$];

    mbus_tx_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_pend(req_pend), .req_priority(req_priority), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_succ(resp_succ),
        .tx_addr(tx_addr), .tx_data(tx_data), .tx_req(tx_req), .tx_pend(tx_pend),
        .tx_priority(tx_priority), .tx_resp_ack(tx_resp_ack),
        .tx_ack(tx_ack), .tx_succ(tx_succ), .tx_fail(tx_fail)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Requesters: present queued words, advance on req_ready, withdraw on an abort
    initial begin : requesters
        int   seen;
        msg_t cur [N];
        bit   busy [N];
        int   widx [N];
        int   gap [N];
        seen = 0;
        for (int i = 0; i < N; i++) begin busy[i] = 0; widx[i] = 0; gap[i] = 0; end
        req_valid = '0; req_pend = '0; req_priority = '0; req_addr = '0; req_data = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                for (int i = 0; i < N; i++) busy[i] = 0;
                seen = batch_id;
            end else begin
                if (seen != batch_id) begin
                    seen = batch_id;
                    for (int i = 0; i < N; i++) begin
                        if (new_has[i]) begin cur[i] = new_msg[i]; busy[i] = 1; widx[i] = 0; gap[i] = 0; end
                    end
                end
                for (int i = 0; i < N; i++) begin
                    if (busy[i] && req_ready[i]) begin
                        widx[i]++;
                        if (widx[i] >= cur[i].nw) busy[i] = 0;
                        else gap[i] = int'(cur[i].gap[widx[i]]);
                    end
                    if (busy[i] && resp_valid[i]) busy[i] = 0;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (busy[i] && gap[i] == 0) begin
                    req_valid[i] = 1'b1;
                    req_addr[i*AW +: AW] = (widx[i] == 0) ? cur[i].addr : ~cur[i].addr;
                    req_priority[i] = (widx[i] == 0) ? cur[i].prio : 1'($urandom_range(0, 1));
                    req_data[i*DW +: DW] = cur[i].data[widx[i]];
                    req_pend[i] = (widx[i] < cur[i].nw - 1);
                end else begin
                    req_valid[i] = 1'b0;
                    req_data[i*DW +: DW] = $urandom;
                    if (busy[i] && gap[i] > 0) gap[i]--;
                end
            end
        end
    end

    // Node model: word handshake, then result levels chosen by the current message kind
    initial begin : node
        int st, dly, cnt, nk;
        bit last;
        st = 0; dly = 0; cnt = 0; last = 0;
        tx_ack = 1'b0; tx_succ = 1'b0; tx_fail = 1'b0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                st = 0; tx_ack = 1'b0; tx_succ = 1'b0; tx_fail = 1'b0;
            end else begin
                nk = (exp_q.size() > 0) ? exp_q[0].kind : K_SUCC;
                case (st)
                    0: if (tx_req && !hold) begin dly = $urandom_range(0, 3); st = 1; end
                    1: if (dly > 0) dly--;
                       else begin tx_ack = 1'b1; last = !tx_pend; cnt = 0; st = 2; end
                    2: begin
                        cnt++;
                        if (!tx_req) begin chk("ack_to_ready_lat", cnt, 3); dly = $urandom_range(0, 3); st = 3; end
                    end
                    3: if (dly > 0) dly--;
                       else begin
                           tx_ack = 1'b0;
                           if (last) begin dly = $urandom_range(0, 4); st = 4; end
                           else if (nk == K_EARLY) begin dly = 3; st = 6; end
                           else st = 0;
                       end
                    4: if (dly > 0) dly--;
                       else begin
                           tx_succ = (nk == K_SUCC || nk == K_BOTH);
                           tx_fail = (nk != K_SUCC);
                           cnt = 0; st = 5;
                       end
                    6: if (dly > 0) dly--;
                       else begin tx_fail = 1'b1; cnt = 0; st = 5; end
                    5: begin
                        cnt++;
                        if (tx_resp_ack) begin
                            chk("result_to_resp_ack_lat", cnt, 3);
                            tx_succ = 1'b0; tx_fail = 1'b0; cnt = 0; st = 7;
                        end
                    end
                    7: begin
                        cnt++;
                        if (resp_valid != '0) begin chk("result_fall_to_resp_valid_lat", cnt, 3); st = 0; end
                    end
                    default: st = 0;
                endcase
            end
        end
    end

    // Monitor: compare each accepted word and each message result against the queue head
    initial begin : monitor
        int   wc;
        msg_t e;
        wc = 0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                exp_q.delete();
                wc = 0;
            end else begin
                if (req_ready != '0) begin
                    if (exp_q.size() == 0) chk("unexpected_req_ready", req_ready, 0);
                    else begin
                        e = exp_q[0];
                        chk("req_ready_grant", req_ready, 64'(1) << e.idx);
                        chk("tx_addr", tx_addr, e.addr);
                        chk("tx_priority", tx_priority, e.prio_out);
                        chk("tx_data", tx_data, e.data[wc]);
                        chk("tx_pend", tx_pend, (wc < e.nw - 1));
                        wc++;
                    end
                end
                if (resp_valid != '0) begin
                    if (exp_q.size() == 0) chk("unexpected_resp_valid", resp_valid, 0);
                    else begin
                        e = exp_q.pop_front();
                        chk("resp_valid_grant", resp_valid, 64'(1) << e.idx);
                        chk("resp_succ", resp_succ, (e.kind == K_SUCC));
                        chk("words_before_resp", wc, (e.kind == K_EARLY) ? 1 : e.nw);
                        chk("tx_pend_at_resp", tx_pend, 0);
                        chk("tx_req_at_resp", tx_req, 0);
                    end
                    wc = 0;
                end
            end
        end
    end

    function automatic msg_t mk(input int nw, input bit prio, input int kind);
        msg_t m;
        m.idx = 0; m.prio = prio; m.prio_out = 0; m.nw = nw; m.kind = kind;
        m.addr = $urandom;
        for (int w = 0; w < 4; w++) begin
            m.data[w] = $urandom;
            m.gap[w]  = (w == 0) ? 8'd0 : 8'($urandom_range(0, 5));
        end
        if (kind == K_EARLY) m.gap[1] = 8'd25;
        return m;
    endfunction

    task automatic clear_batch();
        for (int i = 0; i < N; i++) new_has[i] = 0;
    endtask

    // Expected service order: priority subset first, then first pending at or after the pointer
    task automatic launch();
        logic [N-1:0] pend, pm, cset;
        int   w, j;
        msg_t e;
        pend = '0;
        for (int i = 0; i < N; i++) if (new_has[i]) pend[i] = 1'b1;
        while (pend != '0) begin
            pm = '0;
            for (int i = 0; i < N; i++) if (pend[i] && new_msg[i].prio) pm[i] = 1'b1;
            cset = (pm != '0) ? pm : pend;
            w = -1;
            for (int k = 0; k < N; k++) begin
                j = (m_ptr + k) % N;
                if (w < 0 && cset[j]) w = j;
            end
            e = new_msg[w];
            e.idx = w;
            e.prio_out = (pm != '0);
            exp_q.push_back(e);
            m_ptr = (w + 1) % N;
            pend[w] = 1'b0;
        end
        batch_id++;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin step(); n++; end
        chk("batch_complete", exp_q.size(), 0);
        step(); step();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_tx_req"}, tx_req, 0);
        chk({tag, "_tx_addr"}, tx_addr, 0);
        chk({tag, "_tx_data"}, tx_data, 0);
        chk({tag, "_ctrl"}, {tx_pend, tx_priority, tx_resp_ack, resp_succ, req_ready, resp_valid}, 0);
    endtask

    initial begin : main
        int n, nreq;
        checks = 0; failures = 0; batch_id = 0; m_ptr = 0; hold = 0;
        clear_batch();
        resetn = 1'b0;
        repeat (3) step();
        chk_all_zero("reset");
        resetn = 1'b1;
        step();

        // Single-word message with first-word latency
        new_msg[0] = mk(1, 0, K_SUCC);
        new_msg[0].addr = 32'h0000_00A0;
        new_msg[0].data[0] = 32'hDEAD_BEEF;
        new_has[0] = 1;
        launch();
        step(); step();
        chk("tx_req_before_2clk", tx_req, 0);
        step();
        chk("tx_req_at_2clk", tx_req, 1);
        wait_done(200);

        // Priority beats round-robin, then plain round-robin from pointer 2
        clear_batch();
        new_msg[1] = mk(1, 0, K_SUCC); new_has[1] = 1;
        new_msg[3] = mk(1, 1, K_SUCC); new_has[3] = 1;
        launch(); wait_done(300);
        clear_batch();
        for (int i = 0; i < 3; i++) begin new_msg[i] = mk(1, 0, K_SUCC); new_has[i] = 1; end
        launch(); wait_done(400);

        // Multi-word message with a long gap while another requester waits
        clear_batch();
        new_msg[2] = mk(3, 0, K_SUCC);
        new_msg[2].gap[1] = 8'd0; new_msg[2].gap[2] = 8'd10;
        new_has[2] = 1;
        new_msg[0] = mk(1, 0, K_SUCC); new_has[0] = 1;
        launch(); wait_done(400);

        // Early fail in NEXTW, then simultaneous succ and fail
        clear_batch();
        new_msg[1] = mk(2, 0, K_EARLY); new_has[1] = 1;
        launch(); wait_done(300);
        clear_batch();
        new_msg[3] = mk(1, 0, K_BOTH); new_has[3] = 1;
        launch(); wait_done(300);

        // Random batches
        for (int b = 0; b < 30; b++) begin
            int nw, kd, r;
            clear_batch();
            nreq = 0;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 2) != 0 || (i == N - 1 && nreq == 0)) begin
                    nw = $urandom_range(1, 4);
                    r  = $urandom_range(0, 7);
                    kd = (r == 5) ? K_FAIL : (r == 6) ? K_BOTH : (r == 7 && nw >= 2) ? K_EARLY : K_SUCC;
                    new_msg[i] = mk(nw, ($urandom_range(0, 3) == 0), kd);
                    new_has[i] = 1;
                    nreq++;
                end
            end
            launch();
            wait_done(1500);
        end

        // Reset while a word is waiting for acknowledge
        clear_batch();
        hold = 1;
        new_msg[0] = mk(1, 0, K_SUCC); new_has[0] = 1;
        launch();
        n = 0;
        while (!tx_req && n < 20) begin step(); n++; end
        chk("reached_send", tx_req, 1);
        #2 resetn = 1'b0;
        #1 chk_all_zero("midsend_reset");
        repeat (3) step();
        resetn = 1'b1;
        hold = 0;
        m_ptr = 0;
        step();
        clear_batch();
        new_msg[2] = mk(2, 0, K_SUCC); new_has[2] = 1;
        launch(); wait_done(300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #800000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
